// File: rtl/mux_pkg.sv
// Shared constants, select type and one-hot helper for the 4:1 lane selector.
package mux_pkg;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_IN-1:0] onehot4(input sel_t sel);
        logic [NUM_IN-1:0] oh;
        case (sel)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux4_lane.sv
// Purely combinational 4:1 selection of one DATA_W-wide lane from a packed lane bus.
module mux4_lane
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic [NUM_IN*DATA_W-1:0] data_inputs,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        lane_out
);

    always_comb begin
        lane_out = data_inputs[0 +: DATA_W];
        case (sel)
            2'd0:    lane_out = data_inputs[0        +: DATA_W];
            2'd1:    lane_out = data_inputs[DATA_W   +: DATA_W];
            2'd2:    lane_out = data_inputs[2*DATA_W +: DATA_W];
            2'd3:    lane_out = data_inputs[3*DATA_W +: DATA_W];
            // Unreachable for 2-state selects; parks on lane 0.
            default: lane_out = data_inputs[0        +: DATA_W];
        endcase
    end

endmodule

// File: rtl/multiplexer_4to1.sv
// Registered 4:1 lane selector: one-cycle latency, in_valid as capture enable,
// plus a registered one-hot of the select that produced mux_out.
module multiplexer_4to1
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_IN*DATA_W-1:0] data_inputs,
    input  logic [SEL_W-1:0]         select,
    output logic [DATA_W-1:0]        mux_out,
    output logic                     out_valid,
    output logic [NUM_IN-1:0]        sel_onehot
);

    logic [DATA_W-1:0] w_lane;
    logic [NUM_IN-1:0] w_onehot;

    logic [DATA_W-1:0] r_mux_out;
    logic              r_out_valid;
    logic [NUM_IN-1:0] r_sel_onehot;

    mux4_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .data_inputs (data_inputs),
        .sel         (select),
        .lane_out    (w_lane)
    );

    assign w_onehot = onehot4(select);

    // Data and one-hot hold when idle; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux_out    <= '0;
            r_out_valid  <= 1'b0;
            r_sel_onehot <= 4'b0001;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_mux_out    <= w_lane;
                r_sel_onehot <= w_onehot;
            end
        end
    end

    assign mux_out    = r_mux_out;
    assign out_valid  = r_out_valid;
    assign sel_onehot = r_sel_onehot;

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Scoreboard bench for multiplexer_4to1: a 1-bit instance and an 8-bit instance.
module tb_multiplexer_4to1;

    typedef struct packed {
        logic       ev;
        logic [7:0] eo;
        logic [3:0] eoh;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DATA_W = 1 instance
    logic       rst1 = 1'b1;
    logic       vld1 = 1'b0;
    logic [3:0] din1 = '0;
    logic [1:0] sel1 = '0;
    logic [0:0] out1;
    logic       ov1;
    logic [3:0] oh1;

    // DATA_W = 8 instance
    logic        rst8 = 1'b1;
    logic        vld8 = 1'b0;
    logic [31:0] din8 = '0;
    logic [1:0]  sel8 = '0;
    logic [7:0]  out8;
    logic        ov8;
    logic [3:0]  oh8;

    multiplexer_4to1 #(
        .DATA_W (1)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst1),
        .in_valid    (vld1),
        .data_inputs (din1),
        .select      (sel1),
        .mux_out     (out1),
        .out_valid   (ov1),
        .sel_onehot  (oh1)
    );

    multiplexer_4to1 #(
        .DATA_W (8)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst8),
        .in_valid    (vld8),
        .data_inputs (din8),
        .select      (sel8),
        .mux_out     (out8),
        .out_valid   (ov8),
        .sel_onehot  (oh8)
    );

    exp_t  q1[$];
    exp_t  q8[$];
    string t1q[$];
    string t8q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive1(input string tag, input logic r, input logic v, input logic [3:0] d,
                          input logic [1:0] s, input logic eo, input logic ev,
                          input logic [3:0] eoh);
        exp_t e;
        @(negedge clk);
        rst1 = r;
        vld1 = v;
        din1 = d;
        sel1 = s;
        e.ev  = ev;
        e.eo  = {7'd0, eo};
        e.eoh = eoh;
        q1.push_back(e);
        t1q.push_back(tag);
    endtask

    task automatic drive8(input string tag, input logic r, input logic v, input logic [31:0] d,
                          input logic [1:0] s, input logic [7:0] eo, input logic ev,
                          input logic [3:0] eoh);
        exp_t e;
        @(negedge clk);
        rst8 = r;
        vld8 = v;
        din8 = d;
        sel8 = s;
        e.ev  = ev;
        e.eo  = eo;
        e.eoh = eoh;
        q8.push_back(e);
        t8q.push_back(tag);
    endtask

    // Each expectation is consumed just after the posedge that follows its drive.
    exp_t  e1;
    exp_t  e8;
    string t1;
    string t8;
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            t1 = t1q.pop_front();
            check_eq({t1, ".mux_out"},    32'(out1), 32'(e1.eo));
            check_eq({t1, ".out_valid"},  32'(ov1),  32'(e1.ev));
            check_eq({t1, ".sel_onehot"}, 32'(oh1),  32'(e1.eoh));
        end
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            t8 = t8q.pop_front();
            check_eq({t8, ".mux_out"},    32'(out8), 32'(e8.eo));
            check_eq({t8, ".out_valid"},  32'(ov8),  32'(e8.ev));
            check_eq({t8, ".sel_onehot"}, 32'(oh8),  32'(e8.eoh));
        end
    end

    initial begin
        // Reset held two cycles
        drive1("rst_a", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);
        drive1("rst_b", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);

        // Sweep 0101
        drive1("s0101_0", 1'b0, 1'b1, 4'b0101, 2'd0, 1'b1, 1'b1, 4'b0001);
        drive1("s0101_1", 1'b0, 1'b1, 4'b0101, 2'd1, 1'b0, 1'b1, 4'b0010);
        drive1("s0101_2", 1'b0, 1'b1, 4'b0101, 2'd2, 1'b1, 1'b1, 4'b0100);
        drive1("s0101_3", 1'b0, 1'b1, 4'b0101, 2'd3, 1'b0, 1'b1, 4'b1000);

        // Sweep 1111 then 1100, data and select changing together
        drive1("s1111_1", 1'b0, 1'b1, 4'b1111, 2'd1, 1'b1, 1'b1, 4'b0010);
        drive1("s1111_2", 1'b0, 1'b1, 4'b1111, 2'd2, 1'b1, 1'b1, 4'b0100);
        drive1("s1100_2", 1'b0, 1'b1, 4'b1100, 2'd2, 1'b1, 1'b1, 4'b0100);
        drive1("s1100_3", 1'b0, 1'b1, 4'b1100, 2'd3, 1'b1, 1'b1, 4'b1000);
        drive1("s1100_0", 1'b0, 1'b1, 4'b1100, 2'd0, 1'b0, 1'b1, 4'b0001);

        // Hold: accept a 1, then idle with flipped data/select
        drive1("hold_acc", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000);
        drive1("hold_a",   1'b0, 1'b0, 4'b0111, 2'd0, 1'b1, 1'b0, 4'b1000);
        drive1("hold_b",   1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 4'b1000);

        // Reset has priority over an accept; reset values persist until next accept
        drive1("rprio",    1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, 1'b0, 4'b0001);
        drive1("rpost",    1'b0, 1'b0, 4'b1111, 2'd3, 1'b0, 1'b0, 4'b0001);
        drive1("racc",     1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010);
        drive1("ridle",    1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0010);

        // 8-bit lanes, back-to-back accepts
        drive8("w8_rst",  1'b1, 1'b0, 32'hD4C3B2A1, 2'd0, 8'h00, 1'b0, 4'b0001);
        drive8("w8_s0",   1'b0, 1'b1, 32'hD4C3B2A1, 2'd0, 8'hA1, 1'b1, 4'b0001);
        drive8("w8_s1",   1'b0, 1'b1, 32'hD4C3B2A1, 2'd1, 8'hB2, 1'b1, 4'b0010);
        drive8("w8_s2",   1'b0, 1'b1, 32'hD4C3B2A1, 2'd2, 8'hC3, 1'b1, 4'b0100);
        drive8("w8_s3",   1'b0, 1'b1, 32'hD4C3B2A1, 2'd3, 8'hD4, 1'b1, 4'b1000);
        drive8("w8_hold", 1'b0, 1'b0, 32'h00000000, 2'd1, 8'hD4, 1'b0, 4'b1000);
        drive8("w8_mix",  1'b0, 1'b1, 32'h5A3C9600, 2'd2, 8'h3C, 1'b1, 4'b0100);
        drive8("w8_rmid", 1'b1, 1'b0, 32'h5A3C9600, 2'd3, 8'h00, 1'b0, 4'b0001);

        @(negedge clk);
        vld1 = 1'b0;
        vld8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("queue_drain", 32'(q1.size() + q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
